// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load, per-word bit order and shift stall.
// Define PISO_PARITY_EN to append one even-parity bit after every data frame.
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             msb_first,
  input  logic             shift,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1} state_e;
`endif

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             msb_q, msb_d;
  logic             load;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  // Handshake: a word is taken on a rising edge where din_valid & din_ready.
  // din_ready is combinational and only rises at the frame handoff point.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    msb_d     = msb_q;
    din_ready = 1'b0;
    load      = 1'b0;
`ifdef PISO_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        din_ready = 1'b1;
        load      = din_valid;
      end
      S_SHIFT: begin
        if (shift) begin
          if (cnt_q == LAST_BIT) begin
`ifdef PISO_PARITY_EN
            state_d = S_PARITY;
`else
            din_ready = 1'b1;
            load      = din_valid;
            if (!din_valid) state_d = S_IDLE;
`endif
          end else begin
            sreg_d = msb_q ? (sreg_q << 1) : (sreg_q >> 1);
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        if (shift) begin
          din_ready = 1'b1;
          load      = din_valid;
          if (!din_valid) state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // A new word overrides whatever the current frame would have done next.
    if (load) begin
      state_d = S_SHIFT;
      sreg_d  = din;
      msb_d   = msb_first;
      cnt_d   = '0;
`ifdef PISO_PARITY_EN
      par_d   = ^din;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      msb_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      msb_q   <= msb_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Outputs are a mux driven purely by registered state.
  always_comb begin
    sout = 1'b0;
    case (state_q)
      S_SHIFT:  sout = msb_q ? sreg_q[WIDTH-1] : sreg_q[0];
`ifdef PISO_PARITY_EN
      S_PARITY: sout = par_q;
`endif
      default:  sout = 1'b0;
    endcase
  end

  assign sout_valid  = (state_q != S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign frame_start = (state_q == S_SHIFT) && (cnt_q == '0);

endmodule
